load_store_unit: RTL and testbench

// - Request/response front end for the byte-addressed data memory in the multicycle CPU.
// - Sits between the datapath/controller and the data memory, and drives that memory's write enable, address, data-in and store-size select.
// - Loads: captures the memory read word and returns the byte-, half- or word-extracted value in a registered MDR.
// - Stores: issues exactly one write cycle.
// - Optionally checks alignment and suppresses misaligned accesses.

---
 rtl/load_store_unit.sv | 131 +++++++++++++
 tb/tb_load_store_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store front end for the multicycle CPU's byte-addressed data memory: IDLE -> ACCESS -> RESP.
// Define LSU_MISALIGN_CHECK_EN to flag and suppress misaligned half/word accesses.
module load_store_unit #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_sext,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic [1:0]        mem_whb,
    input  logic [31:0]       mem_dout
);

    // Store-size codes shared with the data memory (STOREwhb_SW/SH/SB).
    localparam logic [1:0] STOREWHB_SW = 2'b00;
    localparam logic [1:0] STOREWHB_SH = 2'b01;
    localparam logic [1:0] STOREWHB_SB = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic        we_q, sext_q, err_q;
    logic [1:0]  size_q;
    logic        err_d;
    logic [31:0] shift_b, shift_h, load_val;

    // Handshake: a request transfers on a rising edge where req_valid & req_ready;
    // rsp_valid is a single-cycle pulse with no backpressure.
    assign accept = req_valid & req_ready;

`ifdef LSU_MISALIGN_CHECK_EN
    assign err_d = ((req_size == 2'b01) & req_addr[0]) | (req_size[1] & (|req_addr[1:0]));
`else
    assign err_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        mem_we    = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                // Gating with rst keeps a reset sampled this cycle from committing the write.
                mem_we    = we_q & ~err_q & ~rst;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            size_q   <= 2'b10;
            sext_q   <= 1'b0;
            err_q    <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_whb  <= STOREWHB_SW;
        end else if (accept) begin
            we_q     <= req_we;
            size_q   <= req_size;
            sext_q   <= req_sext;
            err_q    <= err_d;
            mem_addr <= req_addr;
            mem_din  <= req_wdata;
            case (req_size)
                2'b00:   mem_whb <= STOREWHB_SB;
                2'b01:   mem_whb <= STOREWHB_SH;
                default: mem_whb <= STOREWHB_SW;
            endcase
        end
    end

    // Lane selection: halves use addr[1] only, so an unchecked odd half reads the aligned lane.
    assign shift_b = mem_dout >> {mem_addr[1:0], 3'b000};
    assign shift_h = mem_dout >> {mem_addr[1], 4'b0000};

    always_comb begin
        load_val = mem_dout;
        case (size_q)
            2'b00:   load_val = {{24{sext_q & shift_b[7]}}, shift_b[7:0]};
            2'b01:   load_val = {{16{sext_q & shift_h[15]}}, shift_h[15:0]};
            default: load_val = mem_dout;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata <= '0;
        end else if (state == S_ACCESS && !we_q && !err_q) begin
            rsp_rdata <= load_val;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random traffic against a byte-array model.
// Expected values follow LSU_MISALIGN_CHECK_EN when it is defined for the build.
module tb_load_store_unit;

    localparam int ADDR_W = 9;
    localparam logic [1:0] WHB_SW = 2'b00;
    localparam logic [1:0] WHB_SH = 2'b01;
    localparam logic [1:0] WHB_SB = 2'b10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_sext = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [1:0]        mem_whb;
    logic [31:0]       mem_dout;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mdr_model = '0;
    logic [7:0]  ref_b [0:511];
    logic [31:0] mem [0:127];
    logic [31:0] rd;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_whb(mem_whb), .mem_dout(mem_dout)
    );

    // clock / reset
    always #5 clk = ~clk;

    // data memory: combinational read, sized write on the rising edge
    assign mem_dout = mem[mem_addr[8:2]];
    always @(posedge clk) begin
        if (mem_we) begin
            case (mem_whb)
                WHB_SB:  mem[mem_addr[8:2]][8*mem_addr[1:0] +: 8] <= mem_din[7:0];
                WHB_SH:  mem[mem_addr[8:2]][16*mem_addr[1] +: 16] <= mem_din[15:0];
                default: mem[mem_addr[8:2]] <= mem_din;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // reference model: memory as bytes, accesses as little-endian byte runs
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic exp_err(input logic [1:0] size, input logic [8:0] addr);
`ifdef LSU_MISALIGN_CHECK_EN
        int n = nbytes(size);
        return (addr % n) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int base_addr(input logic [1:0] size, input logic [8:0] addr);
        int n = nbytes(size);
        return (int'(addr) / n) * n;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sext, input logic [8:0] addr);
        int n = nbytes(size);
        int a = base_addr(size, addr);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_b[a + i]) << (8 * i));
        if (sext && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input int widx);
        logic [31:0] v = '0;
        for (int i = 0; i < 4; i++) v = v | (32'(ref_b[4 * widx + i]) << (8 * i));
        return v;
    endfunction

    // driver: one full request, with junk held on req_* while the unit is busy
    task automatic do_req(input logic we, input logic [1:0] size, input logic sext,
                          input logic [8:0] addr, input logic [31:0] wdata, output logic [31:0] rdata);
        int          n   = nbytes(size);
        logic        err = exp_err(size, addr);
        logic [1:0]  whb = (n == 1) ? WHB_SB : (n == 2) ? WHB_SH : WHB_SW;
        @(negedge clk);
        check("idle_ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_sext = sext;
        req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        check("acc_we", {31'b0, mem_we}, {31'b0, we & ~err});
        check("acc_addr", 32'(mem_addr), 32'(addr));
        check("acc_whb", {30'b0, mem_whb}, {30'b0, whb});
        check("acc_ready", {31'b0, req_ready}, 32'd0);
        check("acc_rvalid", {31'b0, rsp_valid}, 32'd0);
        if (we) check("acc_din", mem_din, wdata);
        if (!err) begin
            if (we) begin
                for (int i = 0; i < n; i++) ref_b[base_addr(size, addr) + i] = 8'(wdata >> (8 * i));
            end else begin
                mdr_model = ref_load(size, sext, addr);
            end
        end
        exp_q.push_back(mdr_model);
        req_we = 1'(($urandom) & 1); req_size = 2'($urandom);
        req_addr = 9'($urandom); req_wdata = $urandom;
        @(negedge clk);
        req_valid = 1'b0;
        check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, err});
        check("rsp_rdata", rsp_rdata, exp_q.pop_front());
        check("rsp_we", {31'b0, mem_we}, 32'd0);
        check("rsp_addr", 32'(mem_addr), 32'(addr));
        check("mem_word", mem[addr[8:2]], ref_word(int'(addr[8:2])));
        rdata = rsp_rdata;
        @(negedge clk);
        check("post_ready", {31'b0, req_ready}, 32'd1);
        check("post_valid", {31'b0, rsp_valid}, 32'd0);
        check("post_err", {31'b0, rsp_err}, 32'd0);
        check("post_we", {31'b0, mem_we}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
        for (int i = 0; i < 512; i++) ref_b[i] = '0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_whb", {30'b0, mem_whb}, {30'b0, WHB_SW});

        do_req(1'b1, 2'b10, 1'b0, 9'h008, 32'hDEAD_BEEF, rd);
        do_req(1'b0, 2'b10, 1'b0, 9'h008, 32'h0, rd);
        check("lw_8", rd, 32'hDEAD_BEEF);
        do_req(1'b0, 2'b00, 1'b1, 9'h00B, 32'h0, rd);
        check("lb_b", rd, 32'hFFFF_FFDE);
        do_req(1'b0, 2'b00, 1'b0, 9'h00A, 32'h0, rd);
        check("lbu_a", rd, 32'h0000_00AD);
        do_req(1'b0, 2'b00, 1'b1, 9'h008, 32'h0, rd);
        check("lb_8", rd, 32'hFFFF_FFEF);
        do_req(1'b1, 2'b01, 1'b0, 9'h00A, 32'h0000_1234, rd);
        do_req(1'b0, 2'b11, 1'b0, 9'h008, 32'h0, rd);
        check("lw_after_sh", rd, 32'h1234_BEEF);
        do_req(1'b0, 2'b01, 1'b1, 9'h008, 32'h0, rd);
        check("lh_8", rd, 32'hFFFF_BEEF);

        do_req(1'b1, 2'b10, 1'b0, 9'h009, 32'h1122_3344, rd);
        do_req(1'b0, 2'b10, 1'b0, 9'h008, 32'h0, rd);
`ifdef LSU_MISALIGN_CHECK_EN
        check("sw_misalign", rd, 32'h1234_BEEF);
`else
        check("sw_misalign", rd, 32'h1122_3344);
`endif

        // reset during ACCESS of sw 0x10 = 0x55
        @(negedge clk);
        check("rstacc_ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_sext = 1'b0;
        req_addr = 9'h010; req_wdata = 32'h55;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rstacc_we", {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mdr_model = '0;
        check("rstacc_ready2", {31'b0, req_ready}, 32'd1);
        check("rstacc_valid", {31'b0, rsp_valid}, 32'd0);
        check("rstacc_rdata", rsp_rdata, 32'd0);
        check("rstacc_mem", mem[4], ref_word(4));
        @(negedge clk);
        check("rstacc_valid2", {31'b0, rsp_valid}, 32'd0);

        for (int k = 0; k < 300; k++) begin
            logic [8:0] a;
            a = ($urandom_range(0, 7) == 0) ? 9'($urandom) : 9'($urandom_range(0, 63));
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), a, $urandom, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
